sysid_access_ctrl: RTL and testbench
====================================

Name: sysid_access_ctrl

Overview:
- Sequencer and arbiter in front of the system-ID slave, a single-bit-address, 32-bit read-only Avalon slave.
- Address 0 returns the ID word; address 1 returns the build timestamp.
- After reset, or on demand, it reads both words, compares them against build-time expectations and flags a match or mismatch.
- Afterwards it shares the slave between two read requesters using round-robin arbitration, with a waitrequest timeout.

Parameters:
EXPECTED_ID, 32'd2, ID word expected at address 0
EXPECTED_TS, 32'd1498981549, timestamp expected at address 1
TIMEOUT, 16, max cycles a read may be held by waitrequest before abort (>=2)
TO_W, 5, timeout counter width (must hold TIMEOUT)

Ports:
clock  in  1  system clock; all logic rising-edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; re-runs the ID/timestamp check
avm_address  out  1  address to sysid slave (0=ID, 1=timestamp)
avm_read  out  1  read strobe to sysid slave
avm_readdata  in  32  read data from slave
avm_waitrequest  in  1  slave stall; tie 0 for the combinational sysid
req0_read, req1_read  in  1  requester read request; level, held until respective valid
req0_address, req1_address  in  1  requester target address; stable while request held
req0_valid, req1_valid  out  1  one-cycle response pulse
rsp_readdata  out  32  response data; valid with reqN_valid
rsp_err  out  1  response aborted by timeout; valid with reqN_valid
check_done  out  1  check completed (level)
id_ok, ts_ok  out  1  captured word equals expectation; meaningful when check_done=1
id_value, ts_value  out  32  last captured ID / timestamp
timeout_err  out  1  sticky: a check read timed out

Behaviour:
- All outputs are registered. Reset value of every output is 0. The round-robin pointer resets to favour req0. FSM resets to CHK_ID.
- States: CHK_ID, CHK_TS, SERVE, XFER, RESP.
- CHK_ID:
  - avm_read=1, avm_address=0.
  - When the cycle has avm_waitrequest=0: capture avm_readdata into id_value, set id_ok=(data==EXPECTED_ID), go to CHK_TS.
- CHK_TS:
  - Same as CHK_ID with address=1, capturing into ts_value / ts_ok, then go to SERVE with check_done=1.
- Latency with waitrequest=0: first cycle after reset release reads ID, second reads timestamp, third has check_done=1.
- Timeout in a check state:
  - Counter clears on state entry and increments each cycle avm_read=1 && avm_waitrequest=1.
  - If the count reaches TIMEOUT-1 while still stalled: abort, deassert avm_read next cycle, set timeout_err, clear the corresponding ok flag and value, advance to the next state as if the read had completed.
- SERVE:
  - avm_read=0.
  - start has priority: clear check_done, id_ok, ts_ok, timeout_err, then go to CHK_ID.
  - Else if any reqN_read is set: grant per round-robin (both requesting: pointer wins; one requesting: it wins), latch its address, go to XFER.
- start outside SERVE is ignored; requests arriving during a check wait until SERVE.
- XFER:
  - avm_read=1, avm_address=latched address.
  - On waitrequest=0: latch data, rsp_err=0, go to RESP.
  - On timeout: latch data=0, rsp_err=1, go to RESP.
- RESP:
  - Pulse reqN_valid for the granted requester only; rsp_readdata and rsp_err held valid that cycle.
  - Pointer moves to the other requester; return to SERVE.
  - Requester must drop reqN_read in the valid cycle.
  - Minimum transfer is 3 cycles (SERVE, XFER, RESP).
- avm_address and avm_read change only on state transitions. avm_read is never asserted in SERVE or RESP.
- Reset mid-transfer abandons the transfer (no valid pulse) and restarts the check.
- rsp_readdata holds its last value between responses. id_value and ts_value hold until the next capture.

Test Plan:
- Reset release, slave returns 2 / 1498981549, waitrequest=0 -> check_done=1 on cycle 3, id_ok=ts_ok=1, timeout_err=0, no avm_read in SERVE.
- Slave returns ID 3 -> id_ok=0, ts_ok=1, id_value=3; start pulse -> check_done drops, re-check completes 3 cycles later with the same result.
- waitrequest held high for the whole CHK_ID -> avm_read drops after 16 cycles, timeout_err=1, id_ok=0, id_value=0; TS read proceeds and ts_ok=1.
- req0 and req1 both raised continuously at SERVE, addresses 0/1 -> grants alternate req0, req1, req0…; each valid carries 2 or 1498981549 respectively; one response per 3 cycles.
- req1_read raised during CHK_ID -> no avm_read for req1 until check_done=1, then served with correct data.
- waitrequest stuck high during a req0 XFER -> req0_valid after 16 stall cycles with rsp_err=1, rsp_readdata=0; next request completes normally with rsp_err=0.

Source files
------------

// File: rtl/sysid_access_ctrl.sv
// sysid_access_ctrl: runs an ID/timestamp self-check against the system-ID
// slave, then shares the slave between two read requesters with round-robin
// arbitration and a waitrequest timeout on every read.
module sysid_access_ctrl #(
  parameter logic [31:0] EXPECTED_ID = 32'd2,
  parameter logic [31:0] EXPECTED_TS = 32'd1498981549,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned TO_W        = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic        req0_read,
  input  logic        req0_address,
  input  logic        req1_read,
  input  logic        req1_address,
  output logic        req0_valid,
  output logic        req1_valid,
  output logic [31:0] rsp_readdata,
  output logic        rsp_err,
  output logic        check_done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    CHK_ID,
    CHK_TS,
    SERVE,
    XFER,
    RESP
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [TO_W-1:0] to_cnt;
  logic            rr_ptr;
  logic            grant;

  logic            stalled;
  logic            read_done;
  logic            read_abort;
  logic            any_req;
  logic            grant_next;
  logic            grant_addr;
  logic            chk_state;

  // Read progress, timeout detection and round-robin selection for this cycle.
  always_comb begin
    stalled    = avm_read && avm_waitrequest;
    read_done  = avm_read && !avm_waitrequest;
    read_abort = stalled && (to_cnt == TO_W'(TIMEOUT - 1));
    any_req    = req0_read || req1_read;
    chk_state  = (state == CHK_ID) || (state == CHK_TS);
    if (req0_read && req1_read) begin
      grant_next = rr_ptr;
    end else begin
      grant_next = req1_read;
    end
    grant_addr = grant_next ? req1_address : req0_address;
  end

  // Next-state logic; a timed-out read advances exactly like a completed one.
  always_comb begin
    next_state = state;
    case (state)
      CHK_ID: if (read_done || read_abort) next_state = CHK_TS;
      CHK_TS: if (read_done || read_abort) next_state = SERVE;
      SERVE: begin
        if (start) begin
          next_state = CHK_ID;
        end else if (any_req) begin
          next_state = XFER;
        end
      end
      XFER:   if (read_done || read_abort) next_state = RESP;
      RESP:   next_state = SERVE;
      default: next_state = CHK_ID;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CHK_ID;
    end else begin
      state <= next_state;
    end
  end

  // Stall counter, restarted on every state entry.
  always_ff @(posedge clock) begin
    if (reset || (next_state != state)) begin
      to_cnt <= '0;
    end else if (stalled) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Avalon master outputs; a check state entered with the strobe low (after
  // reset or after an aborted ID read) raises it one cycle later.
  always_ff @(posedge clock) begin
    if (reset) begin
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
    end else if (next_state != state) begin
      case (next_state)
        CHK_ID: begin
          avm_read    <= 1'b1;
          avm_address <= 1'b0;
        end
        CHK_TS: begin
          avm_read    <= !read_abort;
          avm_address <= 1'b1;
        end
        XFER: begin
          avm_read    <= 1'b1;
          avm_address <= grant_addr;
        end
        default: avm_read <= 1'b0;
      endcase
    end else if (chk_state && !avm_read) begin
      avm_read <= 1'b1;
    end
  end

  // Check results: capture, compare, and clear when a re-check is requested.
  always_ff @(posedge clock) begin
    if (reset) begin
      check_done  <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == CHK_ID) begin
        if (read_done) begin
          id_value <= avm_readdata;
          id_ok    <= (avm_readdata == EXPECTED_ID);
        end else if (read_abort) begin
          id_value    <= '0;
          id_ok       <= 1'b0;
          timeout_err <= 1'b1;
        end
      end
      if (state == CHK_TS) begin
        if (read_done) begin
          ts_value   <= avm_readdata;
          ts_ok      <= (avm_readdata == EXPECTED_TS);
          check_done <= 1'b1;
        end else if (read_abort) begin
          ts_value    <= '0;
          ts_ok       <= 1'b0;
          timeout_err <= 1'b1;
          check_done  <= 1'b1;
        end
      end
      if ((state == SERVE) && start) begin
        check_done  <= 1'b0;
        id_ok       <= 1'b0;
        ts_ok       <= 1'b0;
        timeout_err <= 1'b0;
      end
    end
  end

  // Arbitration, response capture and the one-cycle valid pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr       <= 1'b0;
      grant        <= 1'b0;
      req0_valid   <= 1'b0;
      req1_valid   <= 1'b0;
      rsp_readdata <= '0;
      rsp_err      <= 1'b0;
    end else begin
      req0_valid <= 1'b0;
      req1_valid <= 1'b0;
      if ((state == SERVE) && !start && any_req) begin
        grant <= grant_next;
      end
      if (state == XFER) begin
        if (read_done) begin
          rsp_readdata <= avm_readdata;
          rsp_err      <= 1'b0;
          req0_valid   <= !grant;
          req1_valid   <= grant;
        end else if (read_abort) begin
          rsp_readdata <= '0;
          rsp_err      <= 1'b1;
          req0_valid   <= !grant;
          req1_valid   <= grant;
        end
      end
      if (state == RESP) begin
        rr_ptr <= !grant;
      end
    end
  end

endmodule

// File: tb/tb_sysid_access_ctrl.sv
// tb_sysid_access_ctrl: directed scoreboard bench for sysid_access_ctrl.
module tb_sysid_access_ctrl;

  localparam logic [31:0] ID_WORD = 32'd2;
  localparam logic [31:0] TS_WORD = 32'd1498981549;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        req0_read = 1'b0;
  logic        req0_address = 1'b0;
  logic        req1_read = 1'b0;
  logic        req1_address = 1'b0;
  logic        req0_valid;
  logic        req1_valid;
  logic [31:0] rsp_readdata;
  logic        rsp_err;
  logic        check_done;
  logic        id_ok;
  logic        ts_ok;
  logic [31:0] id_value;
  logic [31:0] ts_value;
  logic        timeout_err;

  logic [31:0] slave_id = ID_WORD;
  logic        slave_wait = 1'b0;

  int checks = 0;
  int errors = 0;
  int todo0 = 0;
  int todo1 = 0;
  int cycle = 0;

  typedef struct {
    logic        who;
    logic [31:0] data;
    logic        err;
    int          gap;
  } rsp_t;

  typedef struct {
    logic        id_ok;
    logic        ts_ok;
    logic [31:0] id_v;
    logic [31:0] ts_v;
    logic        tmo;
  } chk_t;

  rsp_t rsp_q[$];
  chk_t chk_q[$];

  assign avm_readdata    = avm_address ? TS_WORD : slave_id;
  assign avm_waitrequest = slave_wait;

  sysid_access_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .req0_read      (req0_read),
    .req0_address   (req0_address),
    .req1_read      (req1_read),
    .req1_address   (req1_address),
    .req0_valid     (req0_valid),
    .req1_valid     (req1_valid),
    .rsp_readdata   (rsp_readdata),
    .rsp_err        (rsp_err),
    .check_done     (check_done),
    .id_ok          (id_ok),
    .ts_ok          (ts_ok),
    .id_value       (id_value),
    .ts_value       (ts_value),
    .timeout_err    (timeout_err)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, actual, required);
    end
  endtask

  task automatic expectRsp(input logic who, input logic [31:0] data,
                           input logic err, input int gap);
    rsp_t e;
    e.who  = who;
    e.data = data;
    e.err  = err;
    e.gap  = gap;
    rsp_q.push_back(e);
  endtask

  task automatic expectChk(input logic iok, input logic tok, input logic [31:0] iv,
                           input logic [31:0] tv, input logic tmo);
    chk_t c;
    c.id_ok = iok;
    c.ts_ok = tok;
    c.id_v  = iv;
    c.ts_v  = tv;
    c.tmo   = tmo;
    chk_q.push_back(c);
  endtask

  // Hands a number of read requests to each requester model.
  task automatic applyStimulus(input int n0, input logic a0, input int n1, input logic a1);
    req0_address = a0;
    req1_address = a1;
    todo0 = n0;
    todo1 = n1;
  endtask

  task automatic pulseStart();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (!(rsp_q.size() == 0 && todo0 == 0 && todo1 == 0 && !req0_read && !req1_read)
           && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput("requests drained", 32'(n < budget), 32'd1);
  endtask

  task automatic waitCheckDone(input int budget);
    int n = 0;
    while (!check_done && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput("check completes", 32'(check_done), 32'd1);
  endtask

  // Requester models: raise read, drop it in the valid cycle, re-raise if more work.
  initial begin
    forever begin
      @(negedge clock);
      if (req0_valid) req0_read = 1'b0;
      else if (!req0_read && todo0 > 0) begin
        req0_read = 1'b1;
        todo0--;
      end
      if (req1_valid) req1_read = 1'b0;
      else if (!req1_read && todo1 > 0) begin
        req1_read = 1'b1;
        todo1--;
      end
    end
  end

  // Monitor: pops expected responses and check results as the DUT presents them.
  initial begin
    logic prev_done = 1'b0;
    int   last_valid = 0;
    rsp_t e;
    chk_t c;
    forever begin
      @(negedge clock);
      cycle++;
      if (req0_valid || req1_valid) begin
        checkOutput("single valid", 32'(req0_valid && req1_valid), 32'd0);
        if (rsp_q.size() == 0) begin
          checkOutput("unexpected response", 32'd1, 32'd0);
        end else begin
          e = rsp_q.pop_front();
          checkOutput("rsp requester", 32'(req1_valid), 32'(e.who));
          checkOutput("rsp data", rsp_readdata, e.data);
          checkOutput("rsp err", 32'(rsp_err), 32'(e.err));
          checkOutput("rsp after check", 32'(check_done), 32'd1);
          if (e.gap != 0) checkOutput("rsp spacing", 32'(cycle - last_valid), 32'(e.gap));
        end
        last_valid = cycle;
      end
      if (check_done && !prev_done) begin
        if (chk_q.size() == 0) begin
          checkOutput("unexpected check", 32'd1, 32'd0);
        end else begin
          c = chk_q.pop_front();
          checkOutput("id_ok", 32'(id_ok), 32'(c.id_ok));
          checkOutput("ts_ok", 32'(ts_ok), 32'(c.ts_ok));
          checkOutput("id_value", id_value, c.id_v);
          checkOutput("ts_value", ts_value, c.ts_v);
          checkOutput("timeout_err", 32'(timeout_err), 32'(c.tmo));
        end
      end
      prev_done = check_done;
    end
  end

  // Directed sequence.
  initial begin
    int n;
    int k;

    repeat (3) @(negedge clock);
    checkOutput("reset avm_read", 32'(avm_read), 32'd0);
    checkOutput("reset check_done", 32'(check_done), 32'd0);
    checkOutput("reset valids", 32'({req0_valid, req1_valid}), 32'd0);
    checkOutput("reset id_value", id_value, 32'd0);

    // Power-on check with a matching slave.
    expectChk(1'b1, 1'b1, ID_WORD, TS_WORD, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("cycle1 avm_read", 32'(avm_read), 32'd1);
    checkOutput("cycle1 avm_address", 32'(avm_address), 32'd0);
    @(negedge clock);
    checkOutput("cycle2 avm_address", 32'(avm_address), 32'd1);
    checkOutput("cycle2 check_done", 32'(check_done), 32'd0);
    @(negedge clock);
    checkOutput("cycle3 check_done", 32'(check_done), 32'd1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("serve avm_read", 32'(avm_read), 32'd0);
      @(negedge clock);
    end

    // Wrong ID word, re-check on start.
    slave_id = 32'd3;
    expectChk(1'b0, 1'b1, 32'd3, TS_WORD, 1'b0);
    pulseStart();
    checkOutput("start clears check_done", 32'(check_done), 32'd0);
    @(negedge clock);
    @(negedge clock);
    checkOutput("recheck latency", 32'(check_done), 32'd1);

    // ID read stalled until abort.
    slave_id = ID_WORD;
    slave_wait = 1'b1;
    expectChk(1'b0, 1'b1, 32'd0, TS_WORD, 1'b1);
    pulseStart();
    n = 0;
    while (avm_read && n < 40) begin
      n++;
      @(negedge clock);
    end
    checkOutput("id stall cycles", 32'(n), 32'd16);
    checkOutput("timeout_err set", 32'(timeout_err), 32'd1);
    slave_wait = 1'b0;
    waitCheckDone(20);

    // Both requesters continuously active: strict alternation, one per 3 cycles.
    @(negedge clock);
    expectRsp(1'b0, ID_WORD, 1'b0, 0);
    expectRsp(1'b1, TS_WORD, 1'b0, 3);
    expectRsp(1'b0, ID_WORD, 1'b0, 3);
    expectRsp(1'b1, TS_WORD, 1'b0, 3);
    expectRsp(1'b0, ID_WORD, 1'b0, 3);
    expectRsp(1'b1, TS_WORD, 1'b0, 3);
    applyStimulus(3, 1'b0, 3, 1'b1);
    waitIdle(80);

    // Request raised during a check waits for it to finish.
    expectChk(1'b1, 1'b1, ID_WORD, TS_WORD, 1'b0);
    pulseStart();
    expectRsp(1'b1, ID_WORD, 1'b0, 0);
    applyStimulus(0, 1'b0, 1, 1'b0);
    waitIdle(40);

    // Stalled transfer aborts with an error response, next one is clean.
    @(negedge clock);
    slave_wait = 1'b1;
    expectRsp(1'b0, 32'd0, 1'b1, 0);
    applyStimulus(1, 1'b1, 0, 1'b0);
    n = 0;
    k = 0;
    while (!req0_valid && k < 80) begin
      @(negedge clock);
      k++;
      if (avm_read) n++;
    end
    checkOutput("xfer stall cycles", 32'(n), 32'd16);
    slave_wait = 1'b0;
    waitIdle(20);
    expectRsp(1'b0, TS_WORD, 1'b0, 0);
    applyStimulus(1, 1'b1, 0, 1'b0);
    waitIdle(40);

    repeat (3) @(negedge clock);
    checkOutput("check queue drained", 32'(chk_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  // Last-resort guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
